// File: rtl/alu_pkg.sv
// Shared opcode map and FSM encoding for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_NOT = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_SLA = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;
  localparam logic [3:0] OP_ADD = 4'd9;
  localparam logic [3:0] OP_SUB = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;
  localparam logic [3:0] OP_CLR = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// WIDTH iterations after start; last is high during the final iteration.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 last,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    last     = busy_q && (cnt_q == CW'(WIDTH - 1));
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (last) busy_d = 1'b0;
    end
  end

  // control: async reset aborts any multiply in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    acc_q    <= acc_d;
    mplier_q <= mplier_d;
  end

  assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered outputs; MUL is delegated to the
// iterative multiplier while everything else completes one cycle after accept.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [3:0]           op,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     result,
  output logic [2*WIDTH-1:0]   product,
  output logic                 of,
  output logic                 zero,
  output logic                 slt
);

  localparam int CW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  state_e state_q, state_d;

  logic               accept, mul_start, mul_last, load_out;
  logic [2*WIDTH-1:0] mul_product;

  logic               vld_p0_q, vld_p0_d;
  logic [WIDTH-1:0]   a_p0_q, a_p0_d, b_p0_q, b_p0_d;
  logic [3:0]         op_p0_q, op_p0_d;

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               of_q, of_d, zero_q, zero_d, slt_q, slt_d;

  logic [WIDTH-1:0]        res_c;
  logic [2*WIDTH-1:0]      prod_c;
  logic                    of_c;
  logic signed [WIDTH-1:0] a_s;
  logic [2*WIDTH-1:0]      sla_ext;
  logic [CW-1:0]           rot;
  logic [CW:0]             rot_inv;
  logic                    big;

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .last    (mul_last),
    .product (mul_product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && op == OP_MUL) state_d = ST_MUL;
      ST_MUL:  if (mul_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    accept    = in_valid && in_ready;
    mul_start = accept && (op == OP_MUL);
    load_out  = vld_p0_q || (state_q == ST_DONE);
  end

  // stage p0: operands captured at accept, held through a multiply
  always_comb begin
    vld_p0_d = accept && (op != OP_MUL);
    a_p0_d   = accept ? a  : a_p0_q;
    b_p0_d   = accept ? b  : b_p0_q;
    op_p0_d  = accept ? op : op_p0_q;
  end

  always_comb begin
    a_s     = a_p0_q;
    big     = |(b_p0_q >> CW);
    rot     = b_p0_q[CW-1:0];
    rot_inv = (CW+1)'(WIDTH) - {1'b0, rot};
    sla_ext = {{WIDTH{1'b0}}, a_p0_q} << b_p0_q;
    res_c   = '0;
    prod_c  = '0;
    of_c    = 1'b0;
    case (op_p0_q)
      OP_NOT: res_c = ~a_p0_q;
      OP_AND: res_c = a_p0_q & b_p0_q;
      OP_OR:  res_c = a_p0_q | b_p0_q;
      OP_SLL: res_c = big ? '0 : (a_p0_q << b_p0_q);
      OP_SRL: res_c = big ? '0 : (a_p0_q >> b_p0_q);
      OP_SLA: begin
        res_c = big ? '0 : sla_ext[WIDTH-1:0];
        of_c  = big ? (|a_p0_q) : ((|sla_ext[2*WIDTH-1:WIDTH]) || (sla_ext[M] != a_p0_q[M]));
      end
      OP_SRA: res_c = big ? {WIDTH{a_p0_q[M]}} : (a_s >>> b_p0_q);
      OP_ROL: res_c = (a_p0_q << rot) | (a_p0_q >> rot_inv);
      OP_ROR: res_c = (a_p0_q >> rot) | (a_p0_q << rot_inv);
      OP_ADD: begin
        res_c = a_p0_q + b_p0_q;
        of_c  = add_ovf(a_p0_q[M], b_p0_q[M], res_c[M]);
      end
      OP_SUB: begin
        res_c = a_p0_q - b_p0_q;
        of_c  = add_ovf(a_p0_q[M], ~b_p0_q[M], res_c[M]);
      end
      OP_MUL: begin
        prod_c = mul_product;
        res_c  = mul_product[WIDTH-1:0];
        of_c   = |mul_product[2*WIDTH-1:WIDTH];
      end
      OP_CLR:  res_c = '0;
      default: res_c = '0;
    endcase
  end

  // stage p1: output registers, updated only when a result completes
  always_comb begin
    out_valid_d = load_out;
    result_d    = load_out ? res_c : result_q;
    product_d   = load_out ? prod_c : product_q;
    of_d        = load_out ? of_c : of_q;
    zero_d      = load_out ? (res_c == '0) : zero_q;
    slt_d       = load_out ? ($signed(a_p0_q) < $signed(b_p0_q)) : slt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      product_q   <= '0;
      of_q        <= 1'b0;
      zero_q      <= 1'b0;
      slt_q       <= 1'b0;
    end else begin
      vld_p0_q    <= vld_p0_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      product_q   <= product_d;
      of_q        <= of_d;
      zero_q      <= zero_d;
      slt_q       <= slt_d;
    end
  end

  always_ff @(posedge clk) begin
    a_p0_q  <= a_p0_d;
    b_p0_q  <= b_p0_d;
    op_p0_q <= op_p0_d;
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign product   = product_q;
  assign of        = of_q;
  assign zero      = zero_q;
  assign slt       = slt_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: WIDTH=8 and WIDTH=16 instances, directed vectors.
module tb_alu_seq;

  logic clk, rst;

  logic        in_valid8, in_ready8, out_valid8, of8, zero8, slt8;
  logic [7:0]  a8, b8, result8;
  logic [3:0]  op8;
  logic [15:0] product8;

  logic        in_valid16, in_ready16, out_valid16, of16, zero16, slt16;
  logic [15:0] a16, b16, result16;
  logic [3:0]  op16;
  logic [31:0] product16;

  typedef struct {
    logic [31:0] res;
    logic [63:0] prod;
    logic        of, zero, slt;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int   ntests = 0;
  int   nfail  = 0;
  int   cyc    = 0;
  bit   done   = 0;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .result(result8),
    .product(product8), .of(of8), .zero(zero8), .slt(slt8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op(op16), .out_valid(out_valid16), .result(result16),
    .product(product16), .of(of16), .zero(zero16), .slt(slt16)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Presents a transaction, holding it until accepted; pushes the expectation.
  task automatic issue(input int w, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic [63:0] ep,
                       input logic eo, input logic ez, input logic es, input int lat,
                       input bit push, output int waits);
    exp_t e;
    if (w == 8) begin
      in_valid8 = 1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      in_valid16 = 1; op16 = op; a16 = a[15:0]; b16 = b[15:0];
    end
    waits = 0;
    while (!(w == 8 ? in_ready8 : in_ready16) && waits < 200) begin
      @(posedge clk); #1;
      waits++;
    end
    if (waits >= 200) begin
      ntests++; nfail++;
      $display("FAIL ready_timeout w=%0d: got in_ready=0 required 1", w);
    end
    @(posedge clk); #1;
    if (push) begin
      e.res = er; e.prod = ep; e.of = eo; e.zero = ez; e.slt = es;
      e.lat = lat; e.acc = cyc;
      if (w == 8) q8.push_back(e);
      else        q16.push_back(e);
    end
  endtask

  task automatic v(input int w, input logic [3:0] op, input logic [31:0] a,
                   input logic [31:0] b, input logic [31:0] er, input logic [63:0] ep,
                   input logic eo, input logic ez, input logic es);
    int wt;
    issue(w, op, a, b, er, ep, eo, ez, es, 1, 1'b1, wt);
  endtask

  task automatic idle();
    in_valid8 = 0; in_valid16 = 0;
  endtask

  task automatic mon(input int w, input logic [31:0] r, input logic [63:0] p,
                     input logic o, input logic z, input logic s);
    exp_t e;
    if ((w == 8 && q8.size() == 0) || (w == 16 && q16.size() == 0)) begin
      ntests++; nfail++;
      $display("FAIL unexpected_out_valid w=%0d cycle %0d: got out_valid=1 required 0", w, cyc);
      return;
    end
    if (w == 8) e = q8.pop_front();
    else        e = q16.pop_front();
    chk($sformatf("w%0d result", w), {32'b0, r}, {32'b0, e.res});
    chk($sformatf("w%0d product", w), p, e.prod);
    chk($sformatf("w%0d of", w), {63'b0, o}, {63'b0, e.of});
    chk($sformatf("w%0d zero", w), {63'b0, z}, {63'b0, e.zero});
    chk($sformatf("w%0d slt", w), {63'b0, s}, {63'b0, e.slt});
    chk($sformatf("w%0d latency", w), 64'(cyc - e.acc), 64'(e.lat));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain w8", 64'(q8.size()), 64'd0);
    chk("drain w16", 64'(q16.size()), 64'd0);
  endtask

  initial begin
    int wt;
    rst = 1; idle();
    a8 = 0; b8 = 0; op8 = 0; a16 = 0; b16 = 0; op16 = 0;
    fork
      begin
        while (!done) begin
          @(negedge clk);
          if (!rst) begin
            if (out_valid8)  mon(8,  {24'b0, result8},  {48'b0, product8},  of8,  zero8,  slt8);
            if (out_valid16) mon(16, {16'b0, result16}, {32'b0, product16}, of16, zero16, slt16);
          end
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset result", {56'b0, result8}, 64'd0);
        chk("reset product", {48'b0, product8}, 64'd0);
        chk("reset flags", {61'b0, of8, zero8, slt8}, 64'd0);
        chk("reset out_valid", {63'b0, out_valid8}, 64'd0);
        chk("reset in_ready", {63'b0, in_ready8}, 64'd1);
        rst = 0;
        @(posedge clk); #1;

        // back-to-back single-cycle ops
        v(8, 4'd1,  32'hCC, 32'hAA, 32'h88, 64'h0, 0, 0, 0);
        v(8, 4'd6,  32'hCC, 32'h08, 32'hFF, 64'h0, 0, 0, 1);
        v(8, 4'd8,  32'hCC, 32'h08, 32'hCC, 64'h0, 0, 0, 1);
        v(8, 4'd3,  32'hCC, 32'h06, 32'h00, 64'h0, 0, 1, 1);
        idle();
        @(posedge clk); #1;
        v(8, 4'd9,  32'h80, 32'h80, 32'h00, 64'h0, 1, 1, 0);
        v(8, 4'd10, 32'h0F, 32'h48, 32'hC7, 64'h0, 0, 0, 1);
        v(8, 4'd5,  32'h05, 32'h02, 32'h14, 64'h0, 0, 0, 0);
        v(8, 4'd5,  32'h40, 32'h01, 32'h80, 64'h0, 1, 0, 0);
        v(8, 4'd4,  32'h80, 32'h09, 32'h00, 64'h0, 0, 1, 1);
        v(8, 4'd6,  32'h70, 32'hC8, 32'h00, 64'h0, 0, 1, 0);
        v(8, 4'd7,  32'h81, 32'h09, 32'h03, 64'h0, 0, 0, 1);
        v(8, 4'd0,  32'h0F, 32'h00, 32'hF0, 64'h0, 0, 0, 0);
        v(8, 4'd13, 32'hFF, 32'hFF, 32'h00, 64'h0, 0, 1, 0);

        // multiply, with a held OR that must wait for the multiplier
        issue(8, 4'd11, 32'h46, 32'h81, 32'h46, 64'h2346, 1, 0, 0, 9, 1'b1, wt);
        issue(8, 4'd2,  32'h0F, 32'hF0, 32'hFF, 64'h0, 0, 0, 0, 1, 1'b1, wt);
        chk("w8 mul in_ready low cycles", 64'(wt), 64'd9);
        idle();
        drain();

        issue(16, 4'd11, 32'hFFFF, 32'hFFFF, 32'h0001, 64'hFFFE0001, 1, 0, 0, 17, 1'b1, wt);
        issue(16, 4'd2,  32'h1200, 32'h0034, 32'h1234, 64'h0, 0, 0, 0, 1, 1'b1, wt);
        chk("w16 mul in_ready low cycles", 64'(wt), 64'd17);
        v(16, 4'd0, 32'h00FF, 32'h0001, 32'hFF00, 64'h0, 0, 0, 0);
        v(16, 4'd2, 32'h0000, 32'h0000, 32'h0000, 64'h0, 0, 1, 0);
        v(16, 4'd0, 32'hFFFF, 32'h0005, 32'h0000, 64'h0, 0, 1, 1);
        v(16, 4'd9, 32'h7FFF, 32'h0001, 32'h8000, 64'h0, 1, 0, 0);
        idle();
        drain();

        // reset three cycles into a multiply: no result may appear
        issue(8, 4'd11, 32'h46, 32'h81, 32'h0, 64'h0, 0, 0, 0, 0, 1'b0, wt);
        idle();
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        #1;
        chk("midmul rst result", {56'b0, result8}, 64'd0);
        chk("midmul rst product", {48'b0, product8}, 64'd0);
        chk("midmul rst flags", {61'b0, of8, zero8, slt8}, 64'd0);
        chk("midmul rst out_valid", {63'b0, out_valid8}, 64'd0);
        chk("midmul rst in_ready", {63'b0, in_ready8}, 64'd1);
        @(posedge clk); #1;
        rst = 0;
        repeat (12) @(posedge clk);
        #1;
        v(8, 4'd15, 32'h05, 32'h03, 32'h00, 64'h0, 0, 1, 0);
        idle();
        drain();
        done = 1;
      end
    join
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
